// File: rtl/topk_select_if.sv
// Score input stream and ranked result stream of the top-K selector.
// slave is the selector side; master is the producer/consumer side.
interface topk_select_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_rank;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_val;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_rank, out_idx, out_val, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_rank, out_idx, out_val, out_last
  );
endinterface

// File: rtl/topk_select.sv
// Streaming top-K selector: keeps a descending K-slot list updated by one
// parallel insertion per accepted score, then emits the slots best-first.
module topk_select #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8,
  parameter int K      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] size,
  topk_select_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic        error
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_COLLECT | accepting scores, inserting into slots
  // S_EMIT    | presenting slot rank_q on the result stream
  // S_DONE    | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT, S_DONE} state_t;

  localparam int unsigned MAX_SIZE = 1 << IDX_W;

  state_t state, state_nxt;

  logic [K-1:0]      slot_vld;
  logic [DATA_W-1:0] slot_val [K];
  logic [IDX_W-1:0]  slot_idx [K];
  logic [IDX_W:0]    count_q;
  logic [IDX_W:0]    size_q;
  logic [2:0]        rank_q;
  logic              error_q;

  logic              legal;
  logic              beat;
  logic              last_beat;
  logic              out_fire;
  logic [K-1:0]      gt;
  logic [K-1:0]      gt_prev;
  logic [K-1:0]      take_new;
  logic [K-1:0]      vld_nxt;
  logic [DATA_W-1:0] sel_val;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_last;

  assign legal     = (size != 32'd0) && (size <= MAX_SIZE);
  assign beat      = (state == S_COLLECT) && bus.in_valid;
  assign last_beat = beat && (count_q == size_q - 1'b1);
  assign out_fire  = (state == S_EMIT) && bus.out_ready;

  // Slots stay sorted with valid entries first, so gt is thermometer-coded
  // and the insertion point is its first set bit.
  always_comb begin
    gt = '0;
    for (int i = 0; i < K; i++)
      gt[i] = !slot_vld[i] || (bus.in_data > slot_val[i]);
    gt_prev  = gt << 1;
    take_new = gt & ~gt_prev;
    vld_nxt  = slot_vld >> 1;
  end

  always_comb begin
    sel_val  = '0;
    sel_idx  = '0;
    sel_last = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (rank_q == 3'(i)) begin
        sel_val  = slot_val[i];
        sel_idx  = slot_idx[i];
        sel_last = !vld_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = legal ? S_COLLECT : S_DONE;
      S_COLLECT: if (last_beat) state_nxt = S_EMIT;
      S_EMIT:    if (out_fire && sel_last) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_COLLECT);
    bus.out_valid = (state == S_EMIT);
    bus.out_rank  = '0;
    bus.out_idx   = '0;
    bus.out_val   = '0;
    bus.out_last  = 1'b0;
    if (state == S_EMIT) begin
      bus.out_rank = rank_q;
      bus.out_idx  = sel_idx;
      bus.out_val  = sel_val;
      bus.out_last = sel_last;
    end
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    error = error_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld <= '0;
      for (int i = 0; i < K; i++) begin
        slot_val[i] <= '0;
        slot_idx[i] <= '0;
      end
      count_q <= '0;
      size_q  <= '0;
      rank_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        if (legal) begin
          slot_vld <= '0;
          count_q  <= '0;
          size_q   <= size[IDX_W:0];
          rank_q   <= '0;
          error_q  <= 1'b0;
        end else begin
          error_q  <= 1'b1;
        end
      end
      if (beat) begin
        count_q <= count_q + 1'b1;
        for (int i = 0; i < K; i++) begin
          if (take_new[i]) begin
            slot_vld[i] <= 1'b1;
            slot_val[i] <= bus.in_data;
            slot_idx[i] <= count_q[IDX_W-1:0];
          end
        end
        // Entries below the insertion point move down one; slot K-1 falls off.
        for (int i = 1; i < K; i++) begin
          if (gt_prev[i]) begin
            slot_vld[i] <= slot_vld[i-1];
            slot_val[i] <= slot_val[i-1];
            slot_idx[i] <= slot_idx[i-1];
          end
        end
      end
      if (out_fire) rank_q <= rank_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_topk_select.sv
// Directed bench for topk_select: a sort-based reference list is compared
// against the result stream every cycle it is valid, plus literal pins.
module tb_topk_select;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;
  localparam int K      = 3;

  typedef struct {
    logic [2:0]        rank;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
    logic              last;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] size;
  logic        busy, done, error;

  topk_select_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  topk_select #(.DATA_W(DATA_W), .IDX_W(IDX_W), .K(K)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .size  (size),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] scores [$];
  ent_t exp_q [$];
  ent_t got_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: repeatedly pick the highest unused score, earliest index on ties.
  function automatic void build_exp(input int n);
    bit used [256];
    int m;
    m = (n < K) ? n : K;
    for (int i = 0; i < 256; i++) used[i] = 1'b0;
    for (int r = 0; r < m; r++) begin
      int best;
      best = -1;
      for (int i = 0; i < n; i++)
        if (!used[i] && (best < 0 || scores[i] > scores[best])) best = i;
      used[best] = 1'b1;
      exp_q.push_back('{3'(r), IDX_W'(best), scores[best], (r == m - 1)});
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_extra: got rank %0d idx %0d with no entry expected", bus.out_rank, bus.out_idx);
      end else begin
        check("out_rank", 64'(bus.out_rank), 64'(exp_q[0].rank));
        check("out_idx",  64'(bus.out_idx),  64'(exp_q[0].idx));
        check("out_val",  64'(bus.out_val),  64'(exp_q[0].val));
        check("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
        if (bus.out_ready) begin
          got_q.push_back('{bus.out_rank, bus.out_idx, bus.out_val, bus.out_last});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_vector(input int n, input int rdy_mode, input int gap_max);
    int acc, guard, waitc, ph, m, g;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    m = (n < K) ? n : K;
    exp_q.delete();
    got_q.delete();
    build_exp(n);
    bus.out_ready = 1'b0;
    start = 1'b1;
    size  = 32'(n);
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("error_cleared", 64'(error), 64'd0);
    acc = 0;
    guard = 0;
    while (acc < n && guard < 4 * n + 20) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      bus.in_valid = 1'b0;
      repeat (g) begin tick(); guard++; end
      bus.in_valid = 1'b1;
      bus.in_data  = scores[acc];
      if (bus.in_ready) acc++;
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    check("beats_accepted", 64'(acc), 64'(n));
    check("in_ready_drop", 64'(bus.in_ready), 64'd0);
    check("out_valid_first", 64'(bus.out_valid), 64'd1);
    waitc = 0;
    ph = 0;
    while (!done && waitc < 200) begin
      bus.out_ready = (rdy_mode == 0) ? 1'b1 : pat[ph % 4];
      ph++;
      tick();
      waitc++;
    end
    bus.out_ready = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    if (rdy_mode == 0) check("done_latency", 64'(waitc), 64'(m));
    check("entries_left", 64'(exp_q.size()), 64'd0);
    check("entries_got", 64'(got_q.size()), 64'(m));
    tick();
    check("done_pulse_end", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic run_illegal(input logic [31:0] n);
    start = 1'b1;
    size  = n;
    tick();
    start = 1'b0;
    check("ill_done", 64'(done), 64'd1);
    check("ill_error", 64'(error), 64'd1);
    check("ill_in_ready", 64'(bus.in_ready), 64'd0);
    check("ill_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    check("ill_done_end", 64'(done), 64'd0);
    check("ill_idle", 64'(busy), 64'd0);
    check("ill_error_sticky", 64'(error), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_rank"},  64'(bus.out_rank),  64'd0);
    check({tag, "_out_idx"},   64'(bus.out_idx),   64'd0);
    check({tag, "_out_val"},   64'(bus.out_val),   64'd0);
    check({tag, "_out_last"},  64'(bus.out_last),  64'd0);
    check({tag, "_busy"},      64'(busy),          64'd0);
    check({tag, "_done"},      64'(done),          64'd0);
    check({tag, "_error"},     64'(error),         64'd0);
  endtask

  task automatic load(input logic [DATA_W-1:0] v []);
    scores.delete();
    foreach (v[i]) scores.push_back(v[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] v [];
    rst = 1'b1;
    start = 1'b0;
    size = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    v = '{32'd10, 32'd40, 32'd20, 32'd40, 32'd5};
    load(v);
    run_vector(5, 0, 0);
    check("t1_idx0", 64'(got_q[0].idx), 64'd1);
    check("t1_val0", 64'(got_q[0].val), 64'd40);
    check("t1_idx1", 64'(got_q[1].idx), 64'd3);
    check("t1_idx2", 64'(got_q[2].idx), 64'd2);
    check("t1_val2", 64'(got_q[2].val), 64'd20);
    check("t1_last2", 64'(got_q[2].last), 64'd1);

    run_vector(5, 1, 0);
    check("t2_idx1", 64'(got_q[1].idx), 64'd3);
    check("t2_rank2", 64'(got_q[2].rank), 64'd2);

    v = '{32'd7, 32'd9};
    load(v);
    run_vector(2, 0, 0);
    check("t3_idx0", 64'(got_q[0].idx), 64'd1);
    check("t3_val1", 64'(got_q[1].val), 64'd7);
    check("t3_last1", 64'(got_q[1].last), 64'd1);

    run_illegal(32'd0);
    run_illegal(32'd257);

    v = '{32'd3};
    load(v);
    run_vector(1, 0, 0);
    check("t5_val0", 64'(got_q[0].val), 64'd3);
    check("t5_idx0", 64'(got_q[0].idx), 64'd0);

    scores.delete();
    for (int i = 0; i < 256; i++) scores.push_back(DATA_W'(i));
    run_vector(256, 0, 2);
    check("t6_idx0", 64'(got_q[0].idx), 64'd255);
    check("t6_idx1", 64'(got_q[1].idx), 64'd254);
    check("t6_idx2", 64'(got_q[2].idx), 64'd253);

    start = 1'b1;
    size  = 32'd5;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd10;
    tick();
    bus.in_data = 32'd40;
    tick();
    bus.in_data = 32'd20;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    check("abort_no_done", 64'(done), 64'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("abort_idle", 64'(busy), 64'd0);
    v = '{32'd10, 32'd40, 32'd20, 32'd40, 32'd5};
    load(v);
    run_vector(5, 0, 0);
    check("t7_idx0", 64'(got_q[0].idx), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/topk_select.md
# topk_select

Streaming top-K selector downstream of the softmax unit. It consumes one probability/score word per cycle over a valid/ready stream and maintains a sorted K-entry register file in a single-cycle parallel insertion. After the vector ends it emits the K best (index, value) pairs, highest first, to the classification/result logic. Vector length matches the softmax buffer depth (1..256 elements).

## Interface
- DATA_W, 32, score width, unsigned
- IDX_W, 8, class index width (2^IDX_W = max vector length)
- K, 3, number of entries kept and emitted (1..8)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a vector; sampled only in IDLE
- size  in  32  vector length; sampled with start
- in_valid  in  1  input score valid
- in_data  in  DATA_W  input score
- in_ready  out  1  block accepts in_data
- out_valid  out  1  result entry valid
- out_ready  in  1  consumer accepts entry
- out_rank  out  3  rank of entry, 0 = best
- out_idx  out  IDX_W  class index of entry
- out_val  out  DATA_W  score of entry
- out_last  out  1  final entry of this vector
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at vector completion
- error  out  1  sticky: last start had illegal size; cleared by next legal start

## Operation
- States: IDLE, COLLECT, EMIT, DONE.
- IDLE: start=1 with 1 <= size <= 2^IDX_W → clear all K slots (slot valid bits = 0), count=0, error=0, go COLLECT. start=1 with size 0 or > 2^IDX_W → error=1, go DONE (no emission). start=0 → stay.
- COLLECT: in_ready=1. Each in_valid&in_ready beat carries index = count (0-based); count increments. Insertion: new entry placed at first slot p where slot invalid or in_data > slot value (strict); slots p..K-2 shift down one, slot K-1 dropped. No p found → entry discarded. Equal scores: earlier index keeps the higher rank.
- Beat with count = size-1 is the last; next state EMIT (in_ready deasserts the following cycle; no extra beat accepted).
- EMIT: presents slot r (r from 0) while slot r valid. out_valid held, payload stable until out_ready. Handshake advances r. out_last=1 on slot K-1 or on the last valid slot (size < K → only size entries). Handshake with out_last → DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE ignored; size changes outside IDLE ignored.
- Comparisons unsigned DATA_W; count is IDX_W+1 bits, never wraps for legal size.

## Timing
- Reset (async assert, sync release internally not required): state IDLE, in_ready=0, out_valid=0, out_rank=0, out_idx=0, out_val=0, out_last=0, busy=0, done=0, error=0, slots invalid.
- start in IDLE → COLLECT next cycle; in_ready high from that cycle.
- Throughput 1 element/cycle; insertion completes in the accepting cycle (no bubbles).
- Last accepted beat at cycle t → out_valid=1 at t+1 with rank 0.
- With out_ready tied high: K entries on t+1..t+K, done at t+K+1, IDLE (start accepted) at t+K+2.
- Illegal start at t → error=1 and DONE at t+1, done pulse t+1, IDLE t+2.
- in_valid gaps in COLLECT: simply wait, state unchanged.
- rst mid-operation: immediate abort, all outputs to reset values, partial results lost, no done pulse.

## Test plan
- K=3, size=5, scores [10,40,20,40,5], out_ready=1 → (rank0,idx1,40),(rank1,idx3,40),(rank2,idx2,20), out_last on rank2, done 1 cycle later.
- Same vector, out_ready toggled 1-0-0-1 → out_valid stays high, payload stable while stalled, identical sequence, no duplicates or drops.
- K=3, size=2, scores [7,9] → (0,idx1,9),(1,idx0,7) with out_last on rank1; no rank2 emitted.
- size=0 and size=257 → no in_ready, no out_valid, error=1, done pulse at t+1; next start size=1 [3] clears error, emits (0,idx0,3).
- size=256 ascending scores 0..255 with random in_valid gaps → idx255,254,253; exactly 256 beats accepted.
- rst asserted on 3rd beat of size=5 → outputs zero immediately, no done; new start completes normally.
